// File: rtl/fetch_unit_8085_pkg.sv
// Shared types and decode helpers for the 8085 instruction fetch unit.
package pkg_8085;

  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    FETCH_B2 = 3'd1,
    FETCH_B3 = 3'd2,
    PRESENT  = 3'd3,
    HALT     = 3'd4
  } fetch_state_t;

  localparam logic [7:0] OP_HLT = 8'h76;

  // Instruction length in bytes (1..3) from the opcode alone.
  function automatic logic [1:0] instr_len_of(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    if (((op & 8'hCF) == 8'h01) ||
        (op == 8'h22) || (op == 8'h2A) || (op == 8'h32) || (op == 8'h3A) ||
        (op == 8'hC3) || (op == 8'hCD) ||
        ((op & 8'hC7) == 8'hC2) || ((op & 8'hC7) == 8'hC4)) begin
      len = 2'd3;
    end else if (((op & 8'hC7) == 8'h06) || ((op & 8'hC7) == 8'hC6) ||
                 (op == 8'hD3) || (op == 8'hDB)) begin
      len = 2'd2;
    end
    return len;
  endfunction

endpackage

// File: rtl/fetch_unit_8085_len_decode.sv
// Combinational opcode-to-length decoder.
module len_decode_8085
  import pkg_8085::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  assign len = instr_len_of(opcode);

endmodule

// File: rtl/fetch_unit_8085.sv
// 8085 fetch unit: reads 1-3 instruction bytes, presents the whole instruction
// with a valid/ready handshake, stops on HLT and redirects on jump_en.
module fetch_unit_8085
  import pkg_8085::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic [15:0]  mem_addr,
  output logic         mem_rd,
  input  logic [7:0]   mem_data,
  input  logic         mem_ack,
  input  logic         jump_en,
  input  logic [15:0]  jump_addr,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [7:0]   opcode,
  output logic [15:0]  operand,
  output logic [1:0]   instr_len,
  output logic [15:0]  instr_pc,
  output logic         halted,
  output fetch_state_t dbg_state
);

  // Handshake: an instruction moves downstream on any rising edge where
  // instr_valid && instr_ready; while instr_valid is high every presented
  // field is held. A memory byte is taken on an edge with mem_rd && mem_ack.

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         mem_rd_q, mem_rd_d;
  logic         instr_valid_q, instr_valid_d;
  logic         halted_q, halted_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [15:0]  operand_q, operand_d;
  logic [1:0]   instr_len_q, instr_len_d;
  logic [15:0]  instr_pc_q, instr_pc_d;

  logic [1:0]   dec_len;
  logic         got_byte;
  logic         xfer;

  len_decode_8085 u_len_decode (
    .opcode (mem_data),
    .len    (dec_len)
  );

  assign got_byte = mem_rd_q && mem_ack;
  assign xfer     = instr_valid_q && instr_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_rd_d      = mem_rd_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    opcode_d      = opcode_q;
    operand_d     = operand_q;
    instr_len_d   = instr_len_q;
    instr_pc_d    = instr_pc_q;

    if (jump_en) begin
      pc_d          = jump_addr;
      state_d       = FETCH_OP;
      mem_rd_d      = 1'b1;
      instr_valid_d = 1'b0;
      halted_d      = 1'b0;
    end else begin
      unique case (state_q)
        FETCH_OP: begin
          // mem_rd_q is low only in the first cycle out of reset.
          mem_rd_d = 1'b1;
          if (got_byte) begin
            pc_d        = pc_q + 16'd1;
            opcode_d    = mem_data;
            operand_d   = 16'h0000;
            instr_len_d = dec_len;
            instr_pc_d  = pc_q;
            if (dec_len == 2'd1) begin
              state_d       = PRESENT;
              mem_rd_d      = 1'b0;
              instr_valid_d = 1'b1;
            end else begin
              state_d = FETCH_B2;
            end
          end
        end
        FETCH_B2: begin
          if (got_byte) begin
            pc_d           = pc_q + 16'd1;
            operand_d[7:0] = mem_data;
            if (instr_len_q == 2'd3) begin
              state_d = FETCH_B3;
            end else begin
              state_d       = PRESENT;
              mem_rd_d      = 1'b0;
              instr_valid_d = 1'b1;
            end
          end
        end
        FETCH_B3: begin
          if (got_byte) begin
            pc_d            = pc_q + 16'd1;
            operand_d[15:8] = mem_data;
            state_d         = PRESENT;
            mem_rd_d        = 1'b0;
            instr_valid_d   = 1'b1;
          end
        end
        PRESENT: begin
          if (xfer) begin
            instr_valid_d = 1'b0;
            if (opcode_q == OP_HLT) begin
              state_d  = HALT;
              halted_d = 1'b1;
              mem_rd_d = 1'b0;
            end else begin
              state_d  = FETCH_OP;
              mem_rd_d = 1'b1;
            end
          end
        end
        HALT: begin
          mem_rd_d = 1'b0;
        end
        default: begin
          state_d = FETCH_OP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH_OP;
      pc_q          <= RESET_PC;
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      opcode_q      <= 8'h00;
      operand_q     <= 16'h0000;
      instr_len_q   <= 2'd1;
      instr_pc_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_rd_q      <= mem_rd_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      opcode_q      <= opcode_d;
      operand_q     <= operand_d;
      instr_len_q   <= instr_len_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign mem_addr    = pc_q;
  assign mem_rd      = mem_rd_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_len   = instr_len_q;
  assign instr_pc    = instr_pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit_8085.sv
// Directed bench for fetch_unit_8085: decode vector table plus reset,
// latency, backpressure, wait-state, redirect, wrap and halt sequences.
module tb_fetch_unit_8085;
  import pkg_8085::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_addr;
  logic         mem_rd;
  logic [7:0]   mem_data;
  logic         mem_ack;
  logic         jump_en;
  logic [15:0]  jump_addr;
  logic         instr_valid;
  logic         instr_ready;
  logic [7:0]   opcode;
  logic [15:0]  operand;
  logic [1:0]   instr_len;
  logic [15:0]  instr_pc;
  logic         halted;
  fetch_state_t dbg_state;

  fetch_unit_8085 #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .instr_len   (instr_len),
    .instr_pc    (instr_pc),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [7:0] mem [0:65535];
  int         wait_n = 0;
  int         wait_cnt = 0;
  logic       ack_tie = 1'b0;

  assign mem_data = mem[mem_addr];
  assign mem_ack  = (mem_rd || ack_tie) && (wait_cnt >= wait_n);

  always @(posedge clk) begin
    if (!mem_rd || mem_ack) wait_cnt <= 0;
    else                    wait_cnt <= wait_cnt + 1;
  end

  // ---------------- monitors ----------------
  logic [41:0] got_q[$];
  logic [41:0] exp_q[$];
  logic [15:0] fetch_addr_q[$];
  int          fetch_cyc_q[$];

  always @(posedge clk) begin
    if (reset && instr_valid && instr_ready)
      got_q.push_back({opcode, operand, instr_len, instr_pc});
    if (reset && mem_rd && mem_ack) begin
      fetch_addr_q.push_back(mem_addr);
      fetch_cyc_q.push_back(cyc);
    end
  end

  logic        stab_on = 1'b0;
  int          stab_err = 0;
  logic        held_pend = 1'b0;
  logic [15:0] held_addr = 16'h0;

  always @(posedge clk) begin
    held_pend = mem_rd && !mem_ack;
    held_addr = mem_addr;
  end
  always @(negedge clk) begin
    if (stab_on && held_pend && !(mem_rd && mem_addr == held_addr))
      stab_err++;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [41:0] pk(input logic [7:0] o, input logic [15:0] d,
                                     input logic [1:0] l, input logic [15:0] p);
    return {o, d, l, p};
  endfunction

  task automatic compare_xfers(input string name);
    while (exp_q.size() > 0) begin
      logic [41:0] e;
      e = exp_q.pop_front();
      if (got_q.size() == 0) check({name, " missing"}, 64'd0, 64'(e));
      else                   check(name, 64'(got_q.pop_front()), 64'(e));
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    fetch_addr_q.delete();
    fetch_cyc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic jump_to(input logic [15:0] a);
    jump_en   = 1'b1;
    jump_addr = a;
    step();
    jump_en   = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!instr_valid && k < 60) begin
      step();
      k++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  b0, b1, b2;
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [1:0]  len;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int k;
    vecs[0]  = '{16'h0010, 8'hC3, 8'h34, 8'h12, 8'hC3, 16'h1234, 2'd3};
    vecs[1]  = '{16'h0200, 8'h3E, 8'h05, 8'h00, 8'h3E, 16'h0005, 2'd2};
    vecs[2]  = '{16'h0210, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 2'd1};
    vecs[3]  = '{16'h0220, 8'h21, 8'hCD, 8'hAB, 8'h21, 16'hABCD, 2'd3};
    vecs[4]  = '{16'h0230, 8'hCA, 8'h78, 8'h56, 8'hCA, 16'h5678, 2'd3};
    vecs[5]  = '{16'h0240, 8'hC4, 8'h11, 8'h22, 8'hC4, 16'h2211, 2'd3};
    vecs[6]  = '{16'h0250, 8'hFE, 8'h7F, 8'h00, 8'hFE, 16'h007F, 2'd2};
    vecs[7]  = '{16'h0260, 8'hD3, 8'h10, 8'h00, 8'hD3, 16'h0010, 2'd2};
    vecs[8]  = '{16'h0270, 8'hDB, 8'h20, 8'h00, 8'hDB, 16'h0020, 2'd2};
    vecs[9]  = '{16'h0280, 8'h3A, 8'h00, 8'h80, 8'h3A, 16'h8000, 2'd3};
    vecs[10] = '{16'h0290, 8'h47, 8'h00, 8'h00, 8'h47, 16'h0000, 2'd1};
    vecs[11] = '{16'h02A0, 8'hC9, 8'h00, 8'h00, 8'hC9, 16'h0000, 2'd1};
    vecs[12] = '{16'h02B0, 8'hCD, 8'h00, 8'h30, 8'hCD, 16'h3000, 2'd3};
    vecs[13] = '{16'h02C0, 8'h22, 8'h34, 8'h12, 8'h22, 16'h1234, 2'd3};
    vecs[14] = '{16'h02D0, 8'hC5, 8'h00, 8'h00, 8'hC5, 16'h0000, 2'd1};
    vecs[15] = '{16'h02E0, 8'h36, 8'h99, 8'h00, 8'h36, 16'h0099, 2'd2};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h3E;
    mem[16'h0001] = 8'h05;
    mem[16'h0002] = 8'h76;

    reset       = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 16'h0000;
    instr_ready = 1'b1;
    ack_tie     = 1'b1;
    wait_n      = 0;

    // ---- reset and run to HLT ----
    repeat (3) step();
    check("reset_outputs",
          64'({mem_rd, instr_valid, halted, opcode, operand, instr_len, instr_pc, mem_addr}),
          64'({1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000, 16'h0000}));
    reset = 1'b1;
    step();
    check("rd_first_cycle", 64'(mem_rd), 64'd1);
    k = 0;
    while (!halted && k < 30) begin step(); k++; end
    check("reach_halt", 64'(halted), 64'd1);
    exp_q.push_back(pk(8'h3E, 16'h0005, 2'd2, 16'h0000));
    exp_q.push_back(pk(8'h76, 16'h0000, 2'd1, 16'h0002));
    compare_xfers("reset_stream");
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_rd || !halted || instr_valid) k++;
      step();
    end
    check("halt_quiet", 64'(k), 64'd0);
    ack_tie = 1'b0;

    // ---- decode table ----
    for (int i = 0; i < 16; i++) begin
      instr_ready = 1'b0;
      mem[vecs[i].addr] = vecs[i].b0;
      if (vecs[i].len >= 2'd2) mem[vecs[i].addr + 16'd1] = vecs[i].b1;
      if (vecs[i].len == 2'd3) mem[vecs[i].addr + 16'd2] = vecs[i].b2;
      jump_to(vecs[i].addr);
      wait_valid(k);
      check($sformatf("vec%0d_fields", i),
            64'({instr_valid, opcode, operand, instr_len, instr_pc}),
            64'({1'b1, vecs[i].op, vecs[i].opnd, vecs[i].len, vecs[i].addr}));
      check($sformatf("vec%0d_latency", i), 64'(k), 64'(vecs[i].len));
    end

    // ---- 3-byte latency, opcode to opcode ----
    instr_ready = 1'b1;
    mem[16'h0013] = 8'h00;
    jump_to(16'h0010);
    clear_logs();
    repeat (6) step();
    exp_q.push_back(pk(8'hC3, 16'h1234, 2'd3, 16'h0010));
    compare_xfers("b3_xfer");
    if (fetch_addr_q.size() >= 4) begin
      check("b3_first_addr", 64'(fetch_addr_q[0]), 64'h0010);
      check("b3_next_addr", 64'(fetch_addr_q[3]), 64'h0013);
      check("b3_gap", 64'(fetch_cyc_q[3] - fetch_cyc_q[0]), 64'd4);
    end else begin
      check("b3_fetch_count", 64'(fetch_addr_q.size()), 64'd4);
    end

    // ---- backpressure ----
    instr_ready = 1'b0;
    jump_to(16'h0200);
    clear_logs();
    wait_valid(k);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(instr_valid && !mem_rd &&
            {opcode, operand, instr_len, instr_pc} == pk(8'h3E, 16'h0005, 2'd2, 16'h0200)))
        k++;
      step();
    end
    check("bp_stable", 64'(k), 64'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    repeat (6) step();
    check("bp_one_xfer", 64'(got_q.size()), 64'd1);
    exp_q.push_back(pk(8'h3E, 16'h0005, 2'd2, 16'h0200));
    compare_xfers("bp_xfer");

    // ---- wait states ----
    instr_ready = 1'b1;
    wait_n = 3;
    jump_to(16'h0220);
    clear_logs();
    stab_err = 0;
    stab_on = 1'b1;
    k = 0;
    while (got_q.size() == 0 && k < 60) begin step(); k++; end
    stab_on = 1'b0;
    check("ws_addr_stable", 64'(stab_err), 64'd0);
    exp_q.push_back(pk(8'h21, 16'hABCD, 2'd3, 16'h0220));
    compare_xfers("ws_xfer");
    if (fetch_cyc_q.size() >= 2) check("ws_gap", 64'(fetch_cyc_q[1] - fetch_cyc_q[0]), 64'd4);
    else                         check("ws_fetch_count", 64'(fetch_cyc_q.size()), 64'd2);
    wait_n = 0;

    // ---- redirect during FETCH_B2 with ack ----
    mem[16'h0300] = 8'hC3;
    mem[16'h0301] = 8'h55;
    mem[16'h0302] = 8'h66;
    mem[16'h0100] = 8'h00;
    jump_to(16'h0300);
    clear_logs();
    step();
    jump_en   = 1'b1;
    jump_addr = 16'h0100;
    step();
    jump_en   = 1'b0;
    check("redir_addr", 64'({mem_rd, instr_valid, mem_addr}), 64'({1'b1, 1'b0, 16'h0100}));
    check("redir_no_old", 64'(got_q.size()), 64'd0);
    repeat (3) step();
    exp_q.push_back(pk(8'h00, 16'h0000, 2'd1, 16'h0100));
    compare_xfers("redir_xfer");

    // ---- PC wrap ----
    mem[16'hFFFF] = 8'h00;
    jump_to(16'hFFFF);
    clear_logs();
    repeat (4) step();
    if (fetch_addr_q.size() >= 2) begin
      check("wrap_first", 64'(fetch_addr_q[0]), 64'hFFFF);
      check("wrap_next", 64'(fetch_addr_q[1]), 64'h0000);
    end else begin
      check("wrap_fetch_count", 64'(fetch_addr_q.size()), 64'd2);
    end

    // ---- halt exit by jump ----
    mem[16'h0400] = 8'h76;
    jump_to(16'h0400);
    k = 0;
    while (!halted && k < 10) begin step(); k++; end
    check("hx_halted", 64'({halted, mem_rd, instr_valid}), 64'({1'b1, 1'b0, 1'b0}));
    jump_en   = 1'b1;
    jump_addr = 16'h0200;
    step();
    jump_en   = 1'b0;
    check("hx_exit", 64'({halted, mem_rd, mem_addr}), 64'({1'b0, 1'b1, 16'h0200}));

    // ---- reset mid-fetch ----
    wait_n = 3;
    jump_to(16'h0010);
    step();
    #2;
    reset = 1'b0;
    #1;
    check("midreset_outputs",
          64'({mem_rd, instr_valid, halted, opcode, operand, instr_len, instr_pc, mem_addr}),
          64'({1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000, 16'h0000}));
    step();
    check("midreset_held", 64'({mem_rd, instr_valid}), 64'd0);
    reset = 1'b1;
    wait_n = 0;
    step();
    check("midreset_restart", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'h0000}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit_8085.md
FETCH_UNIT_8085 -- requirements
Module: fetch_unit_8085

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mem_addr  output  16  program memory byte address.
REQ-005 mem_rd  output  1  read request to program memory.
REQ-006 mem_data  input  8  read data, valid in the cycle mem_ack is high.
REQ-007 mem_ack  input  1  read complete; mem_data is captured on this edge.
REQ-008 jump_en  input  1  redirect request from the execute stage.
REQ-009 jump_addr  input  16  redirect target.
REQ-010 instr_valid  output  1  the complete instruction is presented downstream.
REQ-011 instr_ready  input  1  downstream accepts the instruction.
REQ-012 opcode  output  8  first instruction byte.
REQ-013 operand  output  16  byte2 in [7:0], byte3 in [15:8]; unused bytes are zero.
REQ-014 instr_len  output  2  instruction length: 1, 2 or 3.
REQ-015 instr_pc  output  16  address of the opcode byte.
REQ-016 halted  output  1  HLT has been delivered and fetching is stopped.

Function
REQ-017 The FSM SHALL use the states FETCH_OP, FETCH_B2, FETCH_B3, PRESENT and HALT.
- mem_rd = 1 only in the FETCH_* states.
- mem_addr = PC.
- mem_rd and mem_addr are held stable until mem_ack.
REQ-018 On mem_ack, the captured byte SHALL be stored and PC SHALL increment mod 2^16 (16'hFFFF wraps to 16'h0000).
REQ-019 Length decode SHALL be:
- 3 bytes: 00rr0001 (LXI); 22, 2A, 32, 3A; C3, CD; 11ccc010 (Jcc); 11ccc100 (Ccc).
- 2 bytes: 00rrr110 (MVI); 11xxx110 (immediate ALU); D3; DB.
- 1 byte: all other opcodes.
REQ-020 Transitions:
- FETCH_OP goes to FETCH_B2 (length 2 or 3) or to PRESENT (length 1).
- FETCH_B2 goes to FETCH_B3 (length 3) or to PRESENT.
- FETCH_B3 goes to PRESENT.
REQ-021 In PRESENT, instr_valid = 1 and opcode/operand/instr_len/instr_pc SHALL be held constant until instr_valid && instr_ready.
REQ-022 On transfer, the FSM SHALL go to HALT if opcode == 8'h76, otherwise to FETCH_OP.
REQ-023 Latency with mem_ack and instr_ready tied high: a 1-byte instruction SHALL take 2 cycles opcode-to-opcode, a 2-byte one 3 cycles, and a 3-byte one 4 cycles.
REQ-024 In HALT: halted = 1, mem_rd = 0, instr_valid = 0; the FSM leaves HALT only on jump_en or reset.
REQ-025 jump_en SHALL have priority over every other event in every state:
- PC <= jump_addr.
- Partial bytes and any presented instruction are discarded.
- A mem_ack in the same cycle is ignored.
- Next state is FETCH_OP, with instr_valid = 0 and halted = 0 from the next cycle.
REQ-026 jump_en in PRESENT with instr_ready high in the same cycle SHALL count as a transfer; the redirect still applies, and the following fetch uses jump_addr.

Reset
REQ-027 While reset is low:
- state = FETCH_OP, PC = RESET_PC.
- mem_rd = 0, instr_valid = 0, halted = 0, opcode = operand = 0, instr_len = 1, instr_pc = 0.
REQ-028 mem_rd SHALL first assert in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-fetch SHALL abandon the fetch immediately, with no output glitch to a non-reset value.

Structure
REQ-030 The package pkg_8085 SHALL hold the FSM state typedef, the HLT opcode constant and the length-decode function.
REQ-031 The length decoder SHALL be one combinational sub-module, len_decode_8085.
REQ-032 The fetch unit SHALL drive the instruction inputs of processor_8085_multi; no other sub-modules are permitted.

Verification
REQ-033 Reset: memory {00h:3E, 01h:05, 02h:76}, ack and ready tied 1, reset released.
- Required: opcode 3E, operand 0005, len 2, pc 0000.
- Then opcode 76 at pc 0002.
- Then halted = 1 and mem_rd stays 0.
REQ-034 3-byte: C3 34 12 at 0010h.
- Required: operand 1234, len 3.
- The next mem_addr is 0013h, 4 cycles after the opcode fetch.
REQ-035 Backpressure: instr_ready held 0 for 5 cycles.
- Required: instr_valid and the presented fields are stable for all 5 cycles.
- mem_rd is 0 throughout; exactly one transfer occurs.
REQ-036 Wait states: mem_ack delayed 3 cycles per byte.
- Required: mem_addr is unchanged while waiting.
- The decoded instruction is identical to the zero-wait case.
REQ-037 Redirect: jump_en with jump_addr = 0100h asserted during FETCH_B2, together with mem_ack.
- Required: the byte is dropped and the next mem_addr is 0100h.
- No instruction is presented from the old stream.
REQ-038 Wrap and halt-exit:
- A 1-byte opcode at FFFFh is followed by a fetch at 0000h.
- jump_en in HALT clears halted the next cycle.
